program_loader: RTL and testbench

Byte-stream program loader: the write side of the CPU's instruction memory, which the CPU only ever reads. It accepts a framed byte stream over a valid/ready handshake and assembles 16-bit instructions, high byte first. It writes them sequentially into instruction memory and holds the CPU in reset for the whole session. On completion it verifies an 8-bit checksum and releases the CPU only if the checksum is good.

---
 rtl/program_loader.sv | 153 +++++++++++++++
 tb/tb_program_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Brief    : Framed byte-stream loader that writes 16-bit words into the
//            instruction memory and holds the CPU in reset until verified.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        im_we,
    output logic [7:0]  im_addr,
    output logic [15:0] im_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t      r_state;
    logic [7:0]  r_count;
    logic [7:0]  r_idx;
    logic [7:0]  r_hi;
    logic [7:0]  r_sum;
    logic        r_rx_ready;
    logic        r_im_we;
    logic [7:0]  r_im_addr;
    logic [15:0] r_im_wdata;
    logic        r_cpu_hold;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic        w_xfer;
    logic [7:0]  w_sum_next;

    assign w_xfer     = rx_valid & r_rx_ready;
    assign w_sum_next = r_sum + rx_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= 8'd0;
            r_idx      <= 8'd0;
            r_hi       <= 8'd0;
            r_sum      <= 8'd0;
            r_rx_ready <= 1'b0;
            r_im_we    <= 1'b0;
            r_im_addr  <= 8'd0;
            r_im_wdata <= 16'd0;
            r_cpu_hold <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_im_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_error    <= 1'b0;
                        r_sum      <= 8'd0;
                        r_idx      <= 8'd0;
                        r_cpu_hold <= 1'b1;
                        r_busy     <= 1'b1;
                        r_rx_ready <= 1'b1;
                        r_state    <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (w_xfer) begin
                        r_count <= rx_data;
                        r_sum   <= rx_data;
                        r_state <= (rx_data == 8'd0) ? S_CSUM : S_HI;
                    end
                end
                S_HI: begin
                    if (w_xfer) begin
                        r_hi    <= rx_data;
                        r_sum   <= w_sum_next;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    // Word and address are registered here so they appear during WRITE.
                    if (w_xfer) begin
                        r_sum      <= w_sum_next;
                        r_rx_ready <= 1'b0;
                        r_im_we    <= 1'b1;
                        r_im_addr  <= BASE_ADDR + r_idx;
                        r_im_wdata <= {r_hi, rx_data};
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_idx      <= r_idx + 8'd1;
                    r_rx_ready <= 1'b1;
                    r_state    <= ((r_idx + 8'd1) == r_count) ? S_CSUM : S_HI;
                end
                S_CSUM: begin
                    // Verdict is computed on acceptance so done/error show during FIN.
                    if (w_xfer) begin
                        r_sum      <= w_sum_next;
                        r_rx_ready <= 1'b0;
                        if (w_sum_next == 8'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_busy     <= 1'b0;
                    r_cpu_hold <= r_error;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_ready = r_rx_ready;
    assign im_we    = r_im_we;
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign cpu_hold = r_cpu_hold;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module   : tb_program_loader
// Brief    : Randomized frame-level bench for program_loader, two base addresses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;

    logic        rdy0, we0, hold0, busy0, done0, err0;
    logic [7:0]  addr0;
    logic [15:0] wd0;
    logic        rdy1, we1, hold1, busy1, done1, err1;
    logic [7:0]  addr1;
    logic [15:0] wd1;

    program_loader #(.BASE_ADDR(8'h00)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy0), .im_we(we0), .im_addr(addr0), .im_wdata(wd0),
        .cpu_hold(hold0), .busy(busy0), .done(done0), .error(err0)
    );

    program_loader #(.BASE_ADDR(8'hFF)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy1), .im_we(we1), .im_addr(addr1), .im_wdata(wd1),
        .cpu_hold(hold1), .busy(busy1), .done(done1), .error(err1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit no_gaps = 1'b0;

    logic [23:0] q0[$];
    logic [23:0] q1[$];
    logic [15:0] fw[256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-side monitor: every write pulse lands in a per-DUT log.
    always @(negedge clk) begin
        if (!reset) begin
            if (we0) begin
                q0.push_back({addr0, wd0});
                chk("rdy_in_write", {31'd0, rdy0}, 32'd0);
            end
            if (we1) q1.push_back({addr1, wd1});
        end
    end

    // Presents one byte and holds it until a transfer edge; returns at edge+1.
    task automatic send_byte(input logic [7:0] b, input bit pulse_start);
        int k;
        bit acc;
        if (!no_gaps && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        if (pulse_start) start = 1'b1;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 50) begin
            acc = rdy0;
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
        end
        if (!acc) chk("xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input int n, input logic [7:0] delta, input bit mid_start,
                             input bit check_len);
        int s;
        int ps;
        int t0;
        logic [7:0] csum;
        bit ok;
        q0.delete();
        q1.delete();
        s = n;
        for (int i = 0; i < n; i++) s += fw[i][15:8] + fw[i][7:0];
        csum = 8'(256 - (s % 256)) + delta;
        ok   = (((s + csum) % 256) == 0);
        ps   = mid_start ? $urandom_range(0, 2 * n + 1) : -1;

        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        chk("start_busy", {31'd0, busy0}, 32'd1);
        chk("start_hold", {31'd0, hold0}, 32'd1);
        chk("start_ready", {31'd0, rdy0}, 32'd1);
        chk("start_errclr", {31'd0, err0}, 32'd0);

        send_byte(8'(n), ps == 0);
        for (int i = 0; i < n; i++) begin
            send_byte(fw[i][15:8], ps == 2 * i + 1);
            send_byte(fw[i][7:0], ps == 2 * i + 2);
        end
        send_byte(csum, 1'b0);
        rx_valid = 1'b0;

        chk("fin_done0", {31'd0, done0}, {31'd0, ok});
        chk("fin_err0", {31'd0, err0}, {31'd0, !ok});
        chk("fin_done1", {31'd0, done1}, {31'd0, ok});
        chk("fin_busy", {31'd0, busy0}, 32'd1);
        @(posedge clk);
        #1;
        chk("post_done", {31'd0, done0}, 32'd0);
        chk("post_busy", {31'd0, busy0}, 32'd0);
        chk("post_hold0", {31'd0, hold0}, {31'd0, !ok});
        chk("post_hold1", {31'd0, hold1}, {31'd0, !ok});
        chk("post_err", {31'd0, err0}, {31'd0, !ok});
        if (check_len) chk("session_len", cyc - t0 + 1, 32'd4);

        chk("nwrites0", q0.size(), n);
        chk("nwrites1", q1.size(), n);
        for (int i = 0; i < n && i < q0.size() && i < q1.size(); i++) begin
            chk("wr0", {8'h0, q0[i]}, {8'h0, 8'(i), fw[i]});
            chk("wr1", {8'h0, q1[i]}, {8'h0, 8'(255 + i), fw[i]});
        end
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vals0", {rdy0, we0, addr0, wd0, hold0, busy0, done0, err0}, 32'd0);
        chk("rst_vals1", {rdy1, we1, addr1, wd1, hold1, busy1, done1, err1}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Known frame, good checksum, then the same with the checksum off by one.
        no_gaps = 1'b1;
        fw[0] = 16'h1234;
        fw[1] = 16'hABCD;
        run_frame(2, 8'd0, 1'b0, 1'b0);
        run_frame(2, 8'd1, 1'b0, 1'b0);
        run_frame(0, 8'd0, 1'b0, 1'b1);
        fw[0] = 16'h0001;
        fw[1] = 16'h0002;
        run_frame(2, 8'd0, 1'b0, 1'b0);
        no_gaps = 1'b0;

        for (int f = 0; f < 14; f++) begin
            int n;
            n = (f == 7) ? 255 : $urandom_range(0, 6);
            for (int i = 0; i < n; i++) fw[i] = 16'($urandom);
            run_frame(n, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                      $urandom_range(0, 1) == 1, 1'b0);
        end

        // Asynchronous reset after the first word has been written.
        q0.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'd3, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA5, 1'b0);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_write", q0.size(), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst0", {rdy0, we0, addr0, wd0, hold0, busy0, done0, err0}, 32'd0);
        chk("async_rst1", {rdy1, we1, addr1, wd1, hold1, busy1, done1, err1}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        fw[0] = 16'hBEEF;
        fw[1] = 16'hCAFE;
        run_frame(2, 8'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
